// File: rtl/multi_port_id_manager.sv
// In-order ID pool with multi-port allocate, issue and retire plus out-of-order completion.
// Pointers carry a wrap bit so full and empty are distinguishable without a separate counter.
module multi_port_id_manager #(
  parameter int MAX_IDS        = 8,
  parameter int ALLOC_PORTS    = 2,
  parameter int ISSUE_PORTS    = 2,
  parameter int COMPLETE_PORTS = 3,
  parameter int RETIRE_PORTS   = 4,
  localparam int LOG2_IDS = $clog2(MAX_IDS),
  localparam int PW       = LOG2_IDS + 1,
  localparam int AW       = $clog2(ALLOC_PORTS + 1),
  localparam int IW       = $clog2(ISSUE_PORTS + 1),
  localparam int RW       = $clog2(RETIRE_PORTS + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [AW-1:0]                                 alloc_req,
  output logic [AW-1:0]                                 alloc_grant,
  output logic [ALLOC_PORTS-1:0][LOG2_IDS-1:0]          alloc_ids,
  input  logic [IW-1:0]                                 issue_req,
  output logic [IW-1:0]                                 issue_grant,
  output logic [ISSUE_PORTS-1:0][LOG2_IDS-1:0]          issue_ids,
  input  logic [COMPLETE_PORTS-1:0]                     complete_valid,
  input  logic [COMPLETE_PORTS-1:0][LOG2_IDS-1:0]       complete_id,
  input  logic                                          flush,
  input  logic                                          retire_hold,
  output logic [RW-1:0]                                 retire_count,
  output logic [RETIRE_PORTS-1:0][LOG2_IDS-1:0]         retire_ids,
  output logic [PW-1:0]                                 free_count,
  output logic [PW-1:0]                                 post_issue_count
);

  logic [PW-1:0]             alloc_ptr, issue_ptr, retire_ptr;
  logic [MAX_IDS-1:0]        done, done_next;
  logic [PW-1:0]             pre_issue_cnt, post_issue_cnt, free_cnt;
  logic [PW-1:0]             a_lim, i_lim;
  logic [RW-1:0]             retire_count_next;
  logic                      run;
  logic [LOG2_IDS-1:0]       ridx;
  logic [LOG2_IDS-1:0]       cmp_off;
  logic [COMPLETE_PORTS-1:0] cmp_legal, cmp_issue_hit;
  logic                      illegal_same, illegal_target;

  assign pre_issue_cnt    = alloc_ptr - issue_ptr;
  assign post_issue_cnt   = issue_ptr - retire_ptr;
  assign free_cnt         = PW'(MAX_IDS) - (alloc_ptr - retire_ptr);
  assign free_count       = free_cnt;
  assign post_issue_count = post_issue_cnt;

  // Grants are capped by port count and occupancy; flush suppresses new allocation only.
  always_comb begin
    a_lim = PW'(alloc_req);
    if (a_lim > PW'(ALLOC_PORTS)) a_lim = PW'(ALLOC_PORTS);
    if (a_lim > free_cnt)         a_lim = free_cnt;
    if (flush)                    a_lim = '0;
    alloc_grant = AW'(a_lim);

    i_lim = PW'(issue_req);
    if (i_lim > PW'(ISSUE_PORTS)) i_lim = PW'(ISSUE_PORTS);
    if (i_lim > pre_issue_cnt)    i_lim = pre_issue_cnt;
    issue_grant = IW'(i_lim);
  end

  always_comb begin
    for (int i = 0; i < ALLOC_PORTS; i++)
      alloc_ids[i] = alloc_ptr[LOG2_IDS-1:0] + LOG2_IDS'(i);
    for (int i = 0; i < ISSUE_PORTS; i++)
      issue_ids[i] = issue_ptr[LOG2_IDS-1:0] + LOG2_IDS'(i);
  end

  // Contiguous run of completed post-issue IDs starting at the retire pointer.
  always_comb begin
    retire_count_next = '0;
    run               = 1'b1;
    ridx              = '0;
    for (int i = 0; i < RETIRE_PORTS; i++) begin
      ridx = retire_ptr[LOG2_IDS-1:0] + LOG2_IDS'(i);
      if (run && (PW'(i) < post_issue_cnt) && done[ridx])
        retire_count_next = retire_count_next + RW'(1);
      else
        run = 1'b0;
    end
    if (retire_hold) retire_count_next = '0;
  end

  always_comb begin
    cmp_off       = '0;
    cmp_legal     = '0;
    cmp_issue_hit = '0;
    for (int c = 0; c < COMPLETE_PORTS; c++) begin
      cmp_off      = complete_id[c] - retire_ptr[LOG2_IDS-1:0];
      cmp_legal[c] = {1'b0, cmp_off} < post_issue_cnt;
      for (int i = 0; i < ISSUE_PORTS; i++)
        if ((IW'(i) < issue_grant) && (issue_ids[i] == complete_id[c]))
          cmp_issue_hit[c] = 1'b1;
    end
  end

  // Issue clears done first so a same-cycle completion of the same ID leaves it set.
  always_comb begin
    done_next = done;
    for (int i = 0; i < ISSUE_PORTS; i++)
      if (IW'(i) < issue_grant)
        done_next[issue_ids[i]] = 1'b0;
    for (int c = 0; c < COMPLETE_PORTS; c++)
      if (complete_valid[c] && (cmp_legal[c] || cmp_issue_hit[c]))
        done_next[complete_id[c]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr    <= '0;
      issue_ptr    <= '0;
      retire_ptr   <= '0;
      done         <= '1;
      retire_count <= '0;
      for (int i = 0; i < RETIRE_PORTS; i++)
        retire_ids[i] <= LOG2_IDS'(i);
    end else begin
      if (flush) alloc_ptr <= issue_ptr + PW'(issue_grant);
      else       alloc_ptr <= alloc_ptr + PW'(alloc_grant);
      issue_ptr    <= issue_ptr + PW'(issue_grant);
      retire_ptr   <= retire_ptr + PW'(retire_count_next);
      done         <= done_next;
      retire_count <= retire_count_next;
      for (int i = 0; i < RETIRE_PORTS; i++)
        retire_ids[i] <= retire_ptr[LOG2_IDS-1:0] + LOG2_IDS'(i);
    end
  end

  assign illegal_same   = |(complete_valid & cmp_issue_hit);
  assign illegal_target = |(complete_valid & ~cmp_legal & ~cmp_issue_hit);

  a_no_complete_on_issue: assert property (@(posedge clk) disable iff (!rst) !illegal_same);
  a_complete_post_issue:  assert property (@(posedge clk) disable iff (!rst) !illegal_target);

endmodule

// File: tb/tb_multi_port_id_manager.sv
// Directed bench: retire events are checked by a scoreboard monitor, everything else inline.
module tb_multi_port_id_manager;

  logic             clk;
  logic             rst;
  logic [1:0]       alloc_req;
  logic [1:0]       alloc_grant;
  logic [1:0][2:0]  alloc_ids;
  logic [1:0]       issue_req;
  logic [1:0]       issue_grant;
  logic [1:0][2:0]  issue_ids;
  logic [2:0]       complete_valid;
  logic [2:0][2:0]  complete_id;
  logic             flush;
  logic             retire_hold;
  logic [2:0]       retire_count;
  logic [3:0][2:0]  retire_ids;
  logic [3:0]       free_count;
  logic [3:0]       post_issue_count;

  typedef struct {
    int cnt;
    int ids[4];
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  multi_port_id_manager #(
    .MAX_IDS(8), .ALLOC_PORTS(2), .ISSUE_PORTS(2), .COMPLETE_PORTS(3), .RETIRE_PORTS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_ids(alloc_ids),
    .issue_req(issue_req), .issue_grant(issue_grant), .issue_ids(issue_ids),
    .complete_valid(complete_valid), .complete_id(complete_id),
    .flush(flush), .retire_hold(retire_hold),
    .retire_count(retire_count), .retire_ids(retire_ids),
    .free_count(free_count), .post_issue_count(post_issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input logic [2:0] v, input int a, input int b, input int c);
    complete_valid = v;
    complete_id[0] = 3'(a);
    complete_id[1] = 3'(b);
    complete_id[2] = 3'(c);
  endtask

  task automatic push_exp(input int c, input int a, input int b, input int d, input int e);
    exp_t x;
    x.cnt    = c;
    x.ids[0] = a;
    x.ids[1] = b;
    x.ids[2] = d;
    x.ids[3] = e;
    sb.push_back(x);
  endtask

  // Monitor: every nonzero retire must match the oldest expected retire event.
  always @(negedge clk) begin
    if (rst && retire_count != 0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL retire_unexpected: got count %0d want none", retire_count);
      end else begin
        mon_e = sb.pop_front();
        chk("retire_count", int'(retire_count), mon_e.cnt);
        for (int i = 0; i < 4; i++)
          chk($sformatf("retire_ids[%0d]", i), int'(retire_ids[i]), mon_e.ids[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    alloc_req = '0; issue_req = '0; flush = 1'b0; retire_hold = 1'b0;
    cmp(3'b000, 0, 0, 0);
    #12;
    chk("rst_free", int'(free_count), 8);
    chk("rst_post", int'(post_issue_count), 0);
    chk("rst_retire_count", int'(retire_count), 0);
    for (int i = 0; i < 4; i++) chk("rst_retire_ids", int'(retire_ids[i]), i);
    rst = 1'b1;
    tick();

    // Allocate to full
    alloc_req = 2'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("full_grant", int'(alloc_grant), (k < 4) ? 2 : 0);
      if (k < 4) begin
        chk("full_id0", int'(alloc_ids[0]), 2 * k);
        chk("full_id1", int'(alloc_ids[1]), 2 * k + 1);
      end
      tick();
    end
    alloc_req = '0;
    #1;
    chk("full_free", int'(free_count), 0);

    // Issue 0..3, complete out of order
    issue_req = 2'd2;
    #1;
    chk("iss_grant_a", int'(issue_grant), 2);
    chk("iss_id_a", int'(issue_ids[0]), 0);
    tick();
    chk("iss_id_b", int'(issue_ids[0]), 2);
    chk("iss_id_b1", int'(issue_ids[1]), 3);
    tick();
    issue_req = '0;
    #1;
    chk("ooo_post", int'(post_issue_count), 4);
    cmp(3'b011, 2, 3, 0);
    tick();
    cmp(3'b000, 0, 0, 0);
    tick(); tick();
    push_exp(1, 0, 1, 2, 3);
    cmp(3'b001, 0, 0, 0);
    tick();
    cmp(3'b000, 0, 0, 0);
    tick(); tick(); tick(); tick();
    push_exp(3, 1, 2, 3, 4);
    cmp(3'b001, 1, 0, 0);
    tick();
    cmp(3'b000, 0, 0, 0);
    tick(); tick(); tick();
    chk("ooo_post_end", int'(post_issue_count), 0);
    chk("ooo_free_end", int'(free_count), 4);

    // Finish 4..7 with a duplicate completion, then wrap
    issue_req = 2'd2;
    #1;
    chk("wr_iss_a", int'(issue_ids[0]), 4);
    tick();
    chk("wr_iss_b", int'(issue_ids[1]), 7);
    tick();
    issue_req = '0;
    push_exp(3, 4, 5, 6, 7);
    cmp(3'b111, 4, 5, 6);
    tick();
    push_exp(1, 7, 0, 1, 2);
    cmp(3'b101, 7, 0, 7);
    tick();
    cmp(3'b000, 0, 0, 0);
    tick(); tick(); tick();
    chk("wr_free8", int'(free_count), 8);
    issue_req = 2'd2;
    #1;
    chk("empty_issue_grant", int'(issue_grant), 0);
    issue_req = '0;
    alloc_req = 2'd2;
    #1;
    chk("wr_grant", int'(alloc_grant), 2);
    chk("wr_id0", int'(alloc_ids[0]), 0);
    chk("wr_id1", int'(alloc_ids[1]), 1);
    tick();
    alloc_req = '0;
    #1;
    chk("wr_free6", int'(free_count), 6);

    // Flush with concurrent issue
    alloc_req = 2'd2;
    tick();
    alloc_req = 2'd1;
    tick();
    alloc_req = '0;
    #1;
    chk("fl_free3", int'(free_count), 3);
    flush = 1'b1; issue_req = 2'd2; alloc_req = 2'd2;
    #1;
    chk("fl_alloc_grant", int'(alloc_grant), 0);
    chk("fl_issue_grant", int'(issue_grant), 2);
    chk("fl_issue_id0", int'(issue_ids[0]), 0);
    tick();
    flush = 1'b0; alloc_req = '0;
    #1;
    chk("fl_pre_empty", int'(issue_grant), 0);
    chk("fl_alloc_id0", int'(alloc_ids[0]), 2);
    chk("fl_post", int'(post_issue_count), 2);
    chk("fl_free", int'(free_count), 6);
    issue_req = '0;

    // Retire hold
    alloc_req = 2'd2;
    tick();
    alloc_req = '0; issue_req = 2'd2;
    #1;
    chk("rh_iss_grant", int'(issue_grant), 2);
    chk("rh_iss_id0", int'(issue_ids[0]), 2);
    tick();
    issue_req = '0;
    retire_hold = 1'b1;
    cmp(3'b111, 0, 1, 2);
    tick();
    cmp(3'b001, 3, 0, 0);
    tick();
    cmp(3'b000, 0, 0, 0);
    tick(); tick();
    chk("rh_held_count", int'(retire_count), 0);
    chk("rh_held_post", int'(post_issue_count), 4);
    push_exp(4, 0, 1, 2, 3);
    retire_hold = 1'b0;
    tick(); tick();
    chk("rh_post_end", int'(post_issue_count), 0);
    chk("rh_free_end", int'(free_count), 8);

    // Reset mid-operation
    alloc_req = 2'd2;
    tick();
    alloc_req = 2'd1;
    tick();
    alloc_req = '0; issue_req = 2'd2;
    tick();
    issue_req = 2'd1;
    tick();
    issue_req = '0;
    #1;
    chk("mr_post3", int'(post_issue_count), 3);
    chk("mr_free5", int'(free_count), 5);
    #1;
    rst = 1'b0;
    issue_req = 2'd2;
    #1;
    chk("mr_free", int'(free_count), 8);
    chk("mr_post", int'(post_issue_count), 0);
    chk("mr_retire_count", int'(retire_count), 0);
    chk("mr_retire_id3", int'(retire_ids[3]), 3);
    chk("mr_alloc_id1", int'(alloc_ids[1]), 1);
    chk("mr_issue_grant", int'(issue_grant), 0);
    issue_req = '0;
    #10;
    rst = 1'b1;
    tick();
    alloc_req = 2'd2;
    #1;
    chk("mr_re_grant", int'(alloc_grant), 2);
    chk("mr_re_id0", int'(alloc_ids[0]), 0);
    tick();
    alloc_req = '0;
    #1;
    chk("mr_re_free", int'(free_count), 6);

    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
